// File: rtl/vx_gpu_pkg.sv
// Shared GPU core definitions used by the dcache request arbiter, LSU and
// shared-memory unit.
//   ARB_IDX_W(n)  : width of a requester index for an n-way arbiter (min 1)
//   dcache_req_t  : dcache request payload at the core's default widths
package VX_gpu_pkg;

    localparam int DCACHE_ADDR_WIDTH = 32;
    localparam int DCACHE_DATA_SIZE  = 4;
    localparam int DCACHE_TAG_WIDTH  = 8;

    // A single requester still carries one index bit so tag layouts never
    // collapse to zero width.
    function automatic int ARB_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                          rw;
        logic [DCACHE_ADDR_WIDTH-1:0]  addr;
        logic [DCACHE_DATA_SIZE*8-1:0] data;
        logic [DCACHE_DATA_SIZE-1:0]   byteen;
        logic [DCACHE_TAG_WIDTH-1:0]   tag;
    } dcache_req_t;

endpackage

// File: rtl/vx_rr_grant.sv
// Combinational round-robin priority encoder.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot grant (zero when nothing requests)
//   idx   : binary index of the granted requester
//   valid : some requester was granted
module vx_rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        // Scan from ptr upward and wrap; ptr is always < N so one
        // subtraction is enough for the modulo.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/vx_dcache_req_arb.sv
// Shares one dcache request/response channel among NUM_INPUTS requesters.
// Requests are round-robin arbitrated into a one-entry registered stage with
// the requester index appended to the tag; responses are routed back by that
// index. Per-requester outstanding-read counters throttle reads and feed busy.
//   in_req_*   : requester-side request channels (flattened per requester)
//   out_req_*  : registered request to the dcache
//   out_rsp_*  : response from the dcache
//   in_rsp_*   : routed responses (data/tag broadcast, valid one-hot)
//   busy       : a read is outstanding or the output stage is full
module vx_dcache_req_arb
    import VX_gpu_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_SIZE   = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,

    input  logic [NUM_INPUTS-1:0]                       in_req_valid,
    input  logic [NUM_INPUTS-1:0]                       in_req_rw,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]            in_req_addr,
    input  logic [NUM_INPUTS*DATA_SIZE*8-1:0]           in_req_data,
    input  logic [NUM_INPUTS*DATA_SIZE-1:0]             in_req_byteen,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0]             in_req_tag,
    output logic [NUM_INPUTS-1:0]                       in_req_ready,

    output logic                                        out_req_valid,
    output logic                                        out_req_rw,
    output logic [ADDR_WIDTH-1:0]                       out_req_addr,
    output logic [DATA_SIZE*8-1:0]                      out_req_data,
    output logic [DATA_SIZE-1:0]                        out_req_byteen,
    output logic [TAG_WIDTH+ARB_IDX_W(NUM_INPUTS)-1:0]  out_req_tag,
    input  logic                                        out_req_ready,

    input  logic                                        out_rsp_valid,
    input  logic [DATA_SIZE*8-1:0]                      out_rsp_data,
    input  logic [TAG_WIDTH+ARB_IDX_W(NUM_INPUTS)-1:0]  out_rsp_tag,
    output logic                                        out_rsp_ready,

    output logic [NUM_INPUTS-1:0]                       in_rsp_valid,
    output logic [NUM_INPUTS*DATA_SIZE*8-1:0]           in_rsp_data,
    output logic [NUM_INPUTS*TAG_WIDTH-1:0]             in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]                       in_rsp_ready,

    output logic                                        busy
);

    localparam int IDX_W  = ARB_IDX_W(NUM_INPUTS);
    localparam int DATA_W = DATA_SIZE * 8;
    localparam int OTAG_W = TAG_WIDTH + IDX_W;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [DATA_SIZE-1:0]  byteen;
        logic [OTAG_W-1:0]     tag;
    } stage_t;

    logic [PEND_W-1:0]     pend      [NUM_INPUTS];
    logic [PEND_W-1:0]     pend_next [NUM_INPUTS];
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  stage_ready;
    logic                  req_fire;
    logic                  valid_next;
    logic                  any_pend_next;
    stage_t                sel;
    stage_t                stage_q;

    logic [IDX_W-1:0]      rsp_idx;
    logic                  rsp_in_range;
    logic                  rsp_fire;
    logic [NUM_INPUTS-1:0] rd_inc;
    logic [NUM_INPUTS-1:0] rsp_dec;
    logic                  dec_at_zero;

    // ---------------- arbitration ----------------

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            eligible[i] = in_req_valid[i]
                       && !(!in_req_rw[i] && (pend[i] == PEND_W'(MAX_PENDING)));
        end
    end

    vx_rr_grant #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .valid (grant_any)
    );

    assign stage_ready = !out_req_valid || out_req_ready;

    // Reset gates ready so nothing is accepted while the stage is held clear.
    assign in_req_ready = (stage_ready && !reset) ? grant : '0;
    assign req_fire     = stage_ready && grant_any && !reset;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel.rw     = in_req_rw[i];
                sel.addr   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel.data   = in_req_data[i*DATA_W +: DATA_W];
                sel.byteen = in_req_byteen[i*DATA_SIZE +: DATA_SIZE];
                sel.tag    = {in_req_tag[i*TAG_WIDTH +: TAG_WIDTH], IDX_W'(i)};
            end
        end
    end

    always_comb begin
        if (req_fire) begin
            valid_next = 1'b1;
        end else if (out_req_ready) begin
            valid_next = 1'b0;
        end else begin
            valid_next = out_req_valid;
        end
    end

    // ---------------- response routing ----------------

    assign rsp_idx = out_rsp_tag[IDX_W-1:0];

    always_comb begin
        in_rsp_valid  = '0;
        out_rsp_ready = 1'b1;   // unroutable index: accept and drop
        rsp_in_range  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (rsp_idx == IDX_W'(i)) begin
                rsp_in_range    = 1'b1;
                in_rsp_valid[i] = out_rsp_valid;
                out_rsp_ready   = in_rsp_ready[i];
            end
        end
    end

    assign in_rsp_data = {NUM_INPUTS{out_rsp_data}};
    assign in_rsp_tag  = {NUM_INPUTS{out_rsp_tag[OTAG_W-1:IDX_W]}};
    assign rsp_fire    = out_rsp_valid && out_rsp_ready;

    // ---------------- pending counters ----------------

    assign rd_inc  = in_req_ready & ~in_req_rw;
    assign rsp_dec = in_rsp_valid & {NUM_INPUTS{out_rsp_ready}};

    always_comb begin
        any_pend_next = 1'b0;
        dec_at_zero   = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pend_next[i] = pend[i];
            if (rd_inc[i] && !rsp_dec[i]) begin
                pend_next[i] = pend[i] + PEND_W'(1);
            end else if (rsp_dec[i] && !rd_inc[i]) begin
                if (pend[i] == '0) begin
                    dec_at_zero = 1'b1;
                end else begin
                    pend_next[i] = pend[i] - PEND_W'(1);
                end
            end
            if (pend_next[i] != '0) begin
                any_pend_next = 1'b1;
            end
        end
    end

    // ---------------- state ----------------

    // busy is its own flop so the core sees a glitch-free level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_req_valid <= 1'b0;
            rr_ptr        <= '0;
            busy          <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pend[i] <= '0;
            end
        end else begin
            out_req_valid <= valid_next;
            busy          <= valid_next || any_pend_next;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pend[i] <= pend_next[i];
            end
            if (req_fire) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0
                                                                : grant_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            stage_q <= sel;
        end
    end

    assign out_req_rw     = stage_q.rw;
    assign out_req_addr   = stage_q.addr;
    assign out_req_data   = stage_q.data;
    assign out_req_byteen = stage_q.byteen;
    assign out_req_tag    = stage_q.tag;

    // ---------------- checks ----------------

    a_no_dec_at_zero : assert property (@(posedge clk) disable iff (reset)
        !dec_at_zero)
        else $error("response for requester with no outstanding read");

    a_rsp_idx_range : assert property (@(posedge clk) disable iff (reset)
        !(out_rsp_valid && !rsp_in_range))
        else $error("response index out of range");

endmodule

// File: tb/tb_vx_dcache_req_arb.sv
module tb_vx_dcache_req_arb;

    localparam int NI = 4;
    localparam int AW = 32;
    localparam int DS = 4;
    localparam int TW = 8;
    localparam int MP = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NI-1:0]    req_valid;
    logic [NI-1:0]    req_rw;
    logic [AW-1:0]    req_addr   [NI];
    logic [DS*8-1:0]  req_data   [NI];
    logic [DS-1:0]    req_byteen [NI];
    logic [TW-1:0]    req_tag    [NI];

    logic [NI*AW-1:0]   f_addr;
    logic [NI*DS*8-1:0] f_data;
    logic [NI*DS-1:0]   f_byteen;
    logic [NI*TW-1:0]   f_tag;

    logic [NI-1:0]      in_req_ready;
    logic               out_req_valid;
    logic               out_req_rw;
    logic [AW-1:0]      out_req_addr;
    logic [DS*8-1:0]    out_req_data;
    logic [DS-1:0]      out_req_byteen;
    logic [TW+IW-1:0]   out_req_tag;
    logic               out_req_ready;
    logic               out_rsp_valid;
    logic [DS*8-1:0]    out_rsp_data;
    logic [TW+IW-1:0]   out_rsp_tag;
    logic               out_rsp_ready;
    logic [NI-1:0]      in_rsp_valid;
    logic [NI*DS*8-1:0] in_rsp_data;
    logic [NI*TW-1:0]   in_rsp_tag;
    logic [NI-1:0]      in_rsp_ready;
    logic               busy;

    always #5 clk = ~clk;

    always_comb begin
        f_addr   = '0;
        f_data   = '0;
        f_byteen = '0;
        f_tag    = '0;
        for (int i = 0; i < NI; i++) begin
            f_addr[i*AW +: AW]     = req_addr[i];
            f_data[i*DS*8 +: DS*8] = req_data[i];
            f_byteen[i*DS +: DS]   = req_byteen[i];
            f_tag[i*TW +: TW]      = req_tag[i];
        end
    end

    vx_dcache_req_arb #(
        .NUM_INPUTS (NI),
        .ADDR_WIDTH (AW),
        .DATA_SIZE  (DS),
        .TAG_WIDTH  (TW),
        .MAX_PENDING(MP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_req_valid  (req_valid),
        .in_req_rw     (req_rw),
        .in_req_addr   (f_addr),
        .in_req_data   (f_data),
        .in_req_byteen (f_byteen),
        .in_req_tag    (f_tag),
        .in_req_ready  (in_req_ready),
        .out_req_valid (out_req_valid),
        .out_req_rw    (out_req_rw),
        .out_req_addr  (out_req_addr),
        .out_req_data  (out_req_data),
        .out_req_byteen(out_req_byteen),
        .out_req_tag   (out_req_tag),
        .out_req_ready (out_req_ready),
        .out_rsp_valid (out_rsp_valid),
        .out_rsp_data  (out_rsp_data),
        .out_rsp_tag   (out_rsp_tag),
        .out_rsp_ready (out_rsp_ready),
        .in_rsp_valid  (in_rsp_valid),
        .in_rsp_data   (in_rsp_data),
        .in_rsp_tag    (in_rsp_tag),
        .in_rsp_ready  (in_rsp_ready),
        .busy          (busy)
    );

    typedef struct {
        logic [TW+IW-1:0] tag;
        logic [AW-1:0]    addr;
        logic [DS*8-1:0]  data;
        logic [DS-1:0]    byteen;
        logic             rw;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int acc_rd2 = 0;

    // Reference model state
    logic m_valid;
    int   m_ptr;
    int   m_pend [NI];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic pend_any();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NI; i++) if (m_pend[i] != 0) r = 1'b1;
        return r;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_ptr   = 0;
        for (int i = 0; i < NI; i++) m_pend[i] = 0;
        sb.delete();
    endtask

    // Called just after a falling edge with inputs already driven; checks
    // the settled outputs, advances the model, and returns after the next
    // falling edge.
    task automatic step();
        logic [NI-1:0] exp_rdy;
        logic [NI-1:0] exp_rv;
        logic          sr;
        logic          rfire;
        int            g;
        int            j;
        int            ridx;
        exp_t          e;
        #1;
        if (reset) model_clear();
        exp_rdy = '0;
        g       = -1;
        if (!reset) begin
            sr = !m_valid || out_req_ready;
            for (int k = 0; k < NI; k++) begin
                j = (m_ptr + k) % NI;
                if (g < 0 && req_valid[j] && !(!req_rw[j] && m_pend[j] == MP)) g = j;
            end
            if (sr && g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("in_req_ready", in_req_ready, exp_rdy);
        chk("out_req_valid", out_req_valid, m_valid);
        chk("busy", busy, m_valid || pend_any());
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("out_tag", out_req_tag, sb[0].tag);
                chk("out_addr", out_req_addr, sb[0].addr);
                chk("out_data", out_req_data, sb[0].data);
                chk("out_byteen", out_req_byteen, sb[0].byteen);
                chk("out_rw", out_req_rw, sb[0].rw);
            end
        end
        ridx   = int'(out_rsp_tag[IW-1:0]);
        exp_rv = out_rsp_valid ? (NI'(1) << ridx) : '0;
        chk("in_rsp_valid", in_rsp_valid, exp_rv);
        chk("out_rsp_ready", out_rsp_ready, in_rsp_ready[ridx]);
        if (out_rsp_valid) chk("in_rsp_tag", in_rsp_tag[ridx*TW +: TW], out_rsp_tag[TW+IW-1:IW]);
        if (in_req_ready[2] && !req_rw[2]) acc_rd2++;
        if (!reset) begin
            rfire = out_rsp_valid && in_rsp_ready[ridx];
            if (m_valid && out_req_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_valid = 1'b0;
            end
            if (g >= 0 && exp_rdy != '0) begin
                e.tag    = {req_tag[g], IW'(g)};
                e.addr   = req_addr[g];
                e.data   = req_data[g];
                e.byteen = req_byteen[g];
                e.rw     = req_rw[g];
                sb.push_back(e);
                m_valid = 1'b1;
                m_ptr   = (g + 1) % NI;
                if (!req_rw[g]) m_pend[g]++;
            end
            if (rfire && m_pend[ridx] > 0) m_pend[ridx]--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_rw        = '0;
        out_req_ready = 1'b1;
        out_rsp_valid = 1'b0;
        out_rsp_data  = 32'hCAFE_F00D;
        out_rsp_tag   = '0;
        in_rsp_ready  = '1;
        for (int i = 0; i < NI; i++) begin
            req_addr[i]   = 32'h1000 + i;
            req_data[i]   = 32'hD000_0000 + i;
            req_byteen[i] = DS'(i + 1);
            req_tag[i]    = TW'(i);
        end
        model_clear();
        @(negedge clk);
        steps(2);
        reset = 1'b0;

        // Round-robin reads from all requesters at 1 grant/cycle.
        req_valid = '1;
        steps(8);
        req_valid = '0;
        steps(2);
        do_reset();

        // Read throttling on requester 2; writes bypass it.
        acc_rd2      = 0;
        req_valid[2] = 1'b1;
        steps(11);
        chk("rd_acc2_throttled", acc_rd2, 8);
        req_rw[2]   = 1'b1;
        req_addr[2] = 32'h2222;
        step();
        req_rw[2]     = 1'b0;
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {8'h77, 2'd2};
        step();
        out_rsp_valid = 1'b0;
        step();
        chk("rd_acc2_after_rsp", acc_rd2, 9);
        req_valid = '0;
        steps(2);
        do_reset();

        // Back-pressure: held payload stays stable.
        out_req_ready = 1'b0;
        req_addr[0]   = 32'h100;
        req_valid[0]  = 1'b1;
        step();
        req_valid[1] = 1'b1;
        steps(5);
        out_req_ready = 1'b1;
        step();
        req_valid = '0;
        steps(2);
        do_reset();

        // Response routed to lane 3 with back-pressure, then released.
        req_valid[3] = 1'b1;
        step();
        req_valid = '0;
        steps(2);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {8'h5A, 2'd3};
        in_rsp_ready  = 4'b0111;
        steps(2);
        in_rsp_ready = '1;
        step();
        out_rsp_valid = 1'b0;
        steps(2);

        // Simultaneous accept and response on requester 1 with pend=3.
        req_valid[1] = 1'b1;
        steps(3);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = {8'h11, 2'd1};
        step();
        out_rsp_valid = 1'b0;
        req_valid     = '0;
        steps(2);

        // Reset with the stage full and four reads outstanding.
        req_valid[1] = 1'b1;
        step();
        req_valid     = '0;
        out_req_ready = 1'b0;
        step();
        reset = 1'b1;
        steps(2);
        reset         = 1'b0;
        out_req_ready = 1'b1;
        req_valid     = '1;
        steps(3);
        req_valid = '0;
        steps(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
